// File: rtl/debounce_bank_if.sv
// Switch-side bundle for debounce_bank: tick enable and raw switches in,
// debounced levels and edge strobes out.
interface debounce_bank_if #(
    parameter int N_CH = 4
);
    logic            i_EN;
    logic [N_CH-1:0] i_SW;
    logic [N_CH-1:0] o_DB;
    logic [N_CH-1:0] o_RISE;
    logic [N_CH-1:0] o_FALL;

    modport master (
        output i_EN,
        output i_SW,
        input  o_DB,
        input  o_RISE,
        input  o_FALL
    );

    modport slave (
        input  i_EN,
        input  i_SW,
        output o_DB,
        output o_RISE,
        output o_FALL
    );
endinterface

// File: rtl/debounce_bank.sv
// N-channel switch debouncer: per-channel synchroniser and debounce FSM sharing one
// divided tick. MODE 0 reacts at once then locks out; MODE 1 reacts after a stable window.
module debounce_bank #(
    parameter int N_CH         = 4,
    parameter int DVSR         = 1000000,
    parameter int STABLE_TICKS = 1,
    parameter int SYNC_STAGES  = 2,
    parameter int MODE         = 0
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    debounce_bank_if.slave   bus
);

    localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int CW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DVSR - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

    typedef enum logic [2:0] {
        ST_ZERO,
        ST_HOLD_ONE,
        ST_ONE,
        ST_HOLD_ZERO,
        ST_WAIT_ONE,
        ST_WAIT_ZERO
    } state_t;

    logic [TW-1:0] tcnt;
    logic          tick;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            tcnt <= '0;
        end else if (!bus.i_EN || tcnt == TICK_LAST) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    assign tick = bus.i_EN && (tcnt == TICK_LAST);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   s;
        state_t                 state;
        logic [CW-1:0]          cnt;
        logic                   db;
        logic                   rise;
        logic                   fall;
        logic                   win_done;

        always_ff @(posedge i_CLK or negedge i_RST_N) begin
            if (!i_RST_N) begin
                sync <= '0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], bus.i_SW[i]};
            end
        end

        assign s        = sync[SYNC_STAGES-1];
        assign win_done = tick && (cnt == CNT_LAST);

        // Level and strobes are written alongside the state so they change on the same edge.
        always_ff @(posedge i_CLK or negedge i_RST_N) begin
            if (!i_RST_N) begin
                state <= ST_ZERO;
                cnt   <= '0;
                db    <= 1'b0;
                rise  <= 1'b0;
                fall  <= 1'b0;
            end else begin
                rise <= 1'b0;
                fall <= 1'b0;
                case (state)
                    ST_ZERO: begin
                        if (s) begin
                            cnt <= '0;
                            if (MODE == 0) begin
                                state <= ST_HOLD_ONE;
                                db    <= 1'b1;
                                rise  <= 1'b1;
                            end else begin
                                state <= ST_WAIT_ONE;
                            end
                        end
                    end
                    ST_ONE: begin
                        if (!s) begin
                            cnt <= '0;
                            if (MODE == 0) begin
                                state <= ST_HOLD_ZERO;
                                db    <= 1'b0;
                                fall  <= 1'b1;
                            end else begin
                                state <= ST_WAIT_ZERO;
                            end
                        end
                    end
                    ST_HOLD_ONE: begin
                        if (win_done) begin
                            state <= ST_ONE;
                        end else if (tick) begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_HOLD_ZERO: begin
                        if (win_done) begin
                            state <= ST_ZERO;
                        end else if (tick) begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_WAIT_ONE: begin
                        // Input falling back before the window closes wins over completion.
                        if (!s) begin
                            state <= ST_ZERO;
                        end else if (win_done) begin
                            state <= ST_ONE;
                            db    <= 1'b1;
                            rise  <= 1'b1;
                        end else if (tick) begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_WAIT_ZERO: begin
                        if (s) begin
                            state <= ST_ONE;
                        end else if (win_done) begin
                            state <= ST_ZERO;
                            db    <= 1'b0;
                            fall  <= 1'b1;
                        end else if (tick) begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= ST_ZERO;
                        db    <= 1'b0;
                    end
                endcase
            end
        end

        assign bus.o_DB[i]   = db;
        assign bus.o_RISE[i] = rise;
        assign bus.o_FALL[i] = fall;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: lockout and verify instances share stimulus and are
// compared each cycle against a window/tick-count reference model plus directed checks.
module tb_debounce_bank;

    localparam int N_CH = 4;
    localparam int DVSR = 4;
    localparam int ST   = 2;
    localparam int SS   = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [N_CH-1:0] sw;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_bank_if #(.N_CH(N_CH)) bus0 ();
    debounce_bank_if #(.N_CH(N_CH)) bus1 ();

    assign bus0.i_EN = en;
    assign bus0.i_SW = sw;
    assign bus1.i_EN = en;
    assign bus1.i_SW = sw;

    debounce_bank #(.N_CH(N_CH), .DVSR(DVSR), .STABLE_TICKS(ST), .SYNC_STAGES(SS), .MODE(0)) dut0 (
        .i_CLK   (clk),
        .i_RST_N (rst_n),
        .bus     (bus0)
    );

    debounce_bank #(.N_CH(N_CH), .DVSR(DVSR), .STABLE_TICKS(ST), .SYNC_STAGES(SS), .MODE(1)) dut1 (
        .i_CLK   (clk),
        .i_RST_N (rst_n),
        .bus     (bus1)
    );

    // Reference model: enabled-cycle phase, delayed switch words, and per-channel
    // "window open / ticks seen" bookkeeping.
    int              phase;
    logic [N_CH-1:0] hist[$];
    bit              m_db   [2][N_CH];
    bit              m_busy [2][N_CH];
    int              m_ticks[2][N_CH];
    bit              m_rise [2][N_CH];
    bit              m_fall [2][N_CH];

    int rise_cnt[2][N_CH];
    int fall_cnt[2][N_CH];
    bit drop0;

    function automatic void model_reset();
        phase = 0;
        hist.delete();
        for (int k = 0; k < SS; k++) hist.push_back('0);
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < N_CH; c++) begin
                m_db[m][c]    = 1'b0;
                m_busy[m][c]  = 1'b0;
                m_ticks[m][c] = 0;
                m_rise[m][c]  = 1'b0;
                m_fall[m][c]  = 1'b0;
            end
        end
    endfunction

    function automatic void model_edge();
        bit              tick;
        bit              s;
        logic [N_CH-1:0] s_word;
        tick   = (en === 1'b1) && (phase == DVSR - 1);
        s_word = hist.pop_front();
        hist.push_back(sw);
        phase  = (en === 1'b1) ? (phase + 1) % DVSR : 0;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < N_CH; c++) begin
                m_rise[m][c] = 1'b0;
                m_fall[m][c] = 1'b0;
                s = s_word[c];
                if (!m_busy[m][c]) begin
                    if (s != m_db[m][c]) begin
                        m_busy[m][c]  = 1'b1;
                        m_ticks[m][c] = 0;
                        if (m == 0) begin
                            m_db[m][c]   = s;
                            m_rise[m][c] = s;
                            m_fall[m][c] = !s;
                        end
                    end
                end else if (m == 1 && s == m_db[m][c]) begin
                    m_busy[m][c] = 1'b0;
                end else if (tick) begin
                    m_ticks[m][c]++;
                    if (m_ticks[m][c] == ST) begin
                        m_busy[m][c] = 1'b0;
                        if (m == 1) begin
                            m_db[m][c]   = s;
                            m_rise[m][c] = s;
                            m_fall[m][c] = !s;
                        end
                    end
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [N_CH-1:0] edb, er, ef;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < N_CH; c++) begin
                edb[c] = m_db[m][c];
                er[c]  = m_rise[m][c];
                ef[c]  = m_fall[m][c];
            end
            if (m == 0) begin
                chk("m0_db", 32'(bus0.o_DB), 32'(edb));
                chk("m0_rise", 32'(bus0.o_RISE), 32'(er));
                chk("m0_fall", 32'(bus0.o_FALL), 32'(ef));
            end else begin
                chk("m1_db", 32'(bus1.o_DB), 32'(edb));
                chk("m1_rise", 32'(bus1.o_RISE), 32'(er));
                chk("m1_fall", 32'(bus1.o_FALL), 32'(ef));
            end
        end
    endtask

    task automatic clear_counts();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < N_CH; c++) begin
                rise_cnt[m][c] = 0;
                fall_cnt[m][c] = 0;
            end
        end
        drop0 = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
        for (int c = 0; c < N_CH; c++) begin
            rise_cnt[0][c] += int'(bus0.o_RISE[c]);
            fall_cnt[0][c] += int'(bus0.o_FALL[c]);
            rise_cnt[1][c] += int'(bus1.o_RISE[c]);
            fall_cnt[1][c] += int'(bus1.o_FALL[c]);
        end
        if (rise_cnt[0][0] > 0 && fall_cnt[0][0] == 0 && !bus0.o_DB[0]) drop0 = 1'b1;
    endtask

    initial begin
        int              lat;
        bit              found;
        logic [N_CH-1:0] r4, f4;

        rst_n = 1'b0;
        en    = 1'b1;
        sw    = '0;
        model_reset();
        clear_counts();
        #1;
        chk("reset_db0", 32'(bus0.o_DB), 32'h0);
        chk("reset_rise0", 32'(bus0.o_RISE), 32'h0);
        chk("reset_db1", 32'(bus1.o_DB), 32'h0);
        chk("reset_fall1", 32'(bus1.o_FALL), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();

        // 1: lockout reacts three edges after the input change
        sw = 4'b0001;
        step();
        step();
        chk("t1_db_before", 32'(bus0.o_DB), 32'h0);
        step();
        chk("t1_db", 32'(bus0.o_DB), 32'h1);
        chk("t1_rise", 32'(bus0.o_RISE), 32'h1);
        step();
        chk("t1_rise_one_cycle", 32'(bus0.o_RISE), 32'h0);
        repeat (20) step();

        // 2: bounce during the hold window gives a single rise, then a single fall
        sw = '0;
        repeat (20) step();
        clear_counts();
        sw[0] = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            sw[0] = ~sw[0];
            step();
        end
        sw[0] = 1'b1;
        repeat (20) step();
        chk("t2_rise_count", 32'(rise_cnt[0][0]), 32'd1);
        sw[0] = 1'b0;
        repeat (20) step();
        chk("t2_fall_count", 32'(fall_cnt[0][0]), 32'd1);
        chk("t2_rise_total", 32'(rise_cnt[0][0]), 32'd1);
        chk("t2_no_drop", 32'(drop0), 32'd0);

        // 3: verify mode rejects a short pulse and accepts a held one
        clear_counts();
        sw[1] = 1'b1;
        repeat (3) step();
        sw[1] = 1'b0;
        repeat (20) step();
        chk("t3_short_db", 32'(bus1.o_DB[1]), 32'd0);
        chk("t3_short_rise", 32'(rise_cnt[1][1]), 32'd0);
        sw[1] = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (lat < 0 && bus1.o_DB[1]) lat = k;
        end
        chk("t3_latency_8_to_11", 32'(lat >= 8 && lat <= 11), 32'd1);
        chk("t3_rise_count", 32'(rise_cnt[1][1]), 32'd1);
        sw[1] = 1'b0;
        repeat (20) step();

        // 4: simultaneous opposite edges on two channels
        sw = 4'b1000;
        repeat (25) step();
        sw = 4'b0100;
        repeat (3) step();
        chk("t4_rise_m0", 32'(bus0.o_RISE), 32'h4);
        chk("t4_fall_m0", 32'(bus0.o_FALL), 32'h8);
        found = 1'b0;
        r4 = '0;
        f4 = '0;
        for (int k = 0; k < 15; k++) begin
            step();
            if ((bus1.o_RISE | bus1.o_FALL) != '0) begin
                found = 1'b1;
                r4 = bus1.o_RISE;
                f4 = bus1.o_FALL;
                break;
            end
        end
        chk("t4_m1_seen", 32'(found), 32'd1);
        chk("t4_rise_m1", 32'(r4), 32'h4);
        chk("t4_fall_m1", 32'(f4), 32'h8);
        repeat (20) step();

        // 5: asynchronous reset in the hold window, then release with the switch held
        sw = '0;
        repeat (20) step();
        sw[0] = 1'b1;
        repeat (3) step();
        chk("t5_rise_pre", 32'(bus0.o_RISE), 32'h1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_db_async", 32'(bus0.o_DB), 32'h0);
        chk("t5_rise_async", 32'(bus0.o_RISE), 32'h0);
        chk("t5_fall_async", 32'(bus0.o_FALL), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("t5_rise_early", 32'(bus0.o_RISE), 32'h0);
        step();
        chk("t5_rise_after", 32'(bus0.o_RISE), 32'h1);
        repeat (20) step();

        // 6: disabled ticks freeze the verify window; enable resumes with fixed latency
        sw = '0;
        repeat (20) step();
        en = 1'b0;
        sw[0] = 1'b1;
        repeat (50) step();
        chk("t6_db_frozen", 32'(bus1.o_DB[0]), 32'd0);
        en = 1'b1;
        repeat (7) step();
        chk("t6_db_pre", 32'(bus1.o_DB[0]), 32'd0);
        step();
        chk("t6_db_after8", 32'(bus1.o_DB[0]), 32'd1);
        chk("t6_rise", 32'(bus1.o_RISE[0]), 32'd1);
        repeat (20) step();

        // Random bouncing and enable gaps against the model
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                int idx;
                idx = int'($urandom_range(0, N_CH - 1));
                sw[idx] = ~sw[idx];
            end
            if ($urandom_range(0, 29) == 0) en = ~en;
            step();
        end
        en = 1'b1;
        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
